iddr_deser: RTL
===============

IDDR_DESER -- requirements
Module: iddr_deser

Interface -- parameters
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent DDR input lanes (1..32).
REQ-002 The block SHALL have parameter RATIO, default 4: bits per lane per output word; even only, 2..16.
REQ-003 The block SHALL have parameter IS_C_INVERTED, default 1'b0: invert C before all capture logic.
REQ-004 The block SHALL have parameter IS_D_INVERTED, default {WIDTH{1'b0}}: per-lane data inversion mask.

Interface -- ports
REQ-005 The block SHALL have port C, input, 1 bit: the single clock; rising and falling edges are used.
REQ-006 The block SHALL have port R_N, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port CE, input, 1 bit: clock enable for pair shift, phase counter and bitslip.
REQ-008 The block SHALL have port D, input, WIDTH bits: DDR serial data, one bit per lane per half-cycle.
REQ-009 The block SHALL have port BITSLIP, input, 1 bit: request a one-bit word-alignment shift, sampled at rising C.
REQ-010 The block SHALL have port Q, output, WIDTH*RATIO bits: lane i occupies Q[i*RATIO +: RATIO]; bit RATIO-1 is the oldest bit, bit 0 the newest.
REQ-011 The block SHALL have port Q_VALID, output, 1 bit: one-cycle strobe marking a new word on Q.

Function
REQ-012 The block SHALL capture each lane at rising c_in into rise register r and at falling c_in into fall register f.
REQ-013 At each rising edge, regardless of CE, the block SHALL form the aligned pair {rp, fp}, with rp <= r and fp <= f (SAME_EDGE_PIPELINED alignment; rp is earlier in time than fp).
REQ-014 On rising edges with CE=1, the block SHALL shift each lane's 2*RATIO-bit history H left by 2: H <= {H[2*RATIO-3:0], rp, fp}.
REQ-015 On rising edges with CE=1, the block SHALL advance phase counter P modulo RATIO/2; with CE=0, H, P and S SHALL hold.
REQ-016 On the CE=1 edge where P == RATIO/2-1, the block SHALL load Q lane i with H_next[S+RATIO-1 : S] and SHALL set Q_VALID=1.
REQ-017 On every other edge, Q_VALID SHALL be 0 and Q SHALL hold its value.
REQ-018 With CE=1 and BITSLIP=1 at a rising edge, the block SHALL update slip offset S <= (S+1) mod RATIO, effective for the next word load; each high cycle counts; BITSLIP with CE=0 SHALL be ignored.
REQ-019 If a slip and a word load coincide, the load SHALL use the old S.
REQ-020 A change to S SHALL NOT alter P or the word cadence: one word per RATIO/2 CE cycles.
REQ-021 The first Q_VALID after reset SHALL occur on the (RATIO/2)th CE rising edge; the first two words may contain reset-value bits.
REQ-022 With RATIO=2, P SHALL be constant 0, Q_VALID SHALL assert on every CE edge, and S SHALL take values 0..1.

Reset
REQ-023 R_N=0 SHALL asynchronously clear r, f, rp, fp, H, P, S, Q and Q_VALID to 0, including the falling-edge register.
REQ-024 Reset asserted mid-word SHALL discard the partial word; after R_N rises, operation SHALL restart as in REQ-021.
REQ-025 Reset deassertion SHALL take effect at the next rising c_in; no Q_VALID SHALL occur before then.

Verification (WIDTH=1, RATIO=4 unless stated)
REQ-026 D=1 constant, CE=1 -> from the third Q_VALID onward Q=4'b1111; Q_VALID pulses every 2nd cycle.
REQ-027 D=1 in the C-high half and 0 in the C-low half -> steady Q=4'b1010; one BITSLIP pulse -> the next-but-one word onward is 4'b0101; a second pulse -> 4'b1010.
REQ-028 Hold CE=0 for 3 cycles mid-word -> Q_VALID stays 0 and Q holds; after CE returns, the word completes after the remaining CE edges with no lost or duplicated bits.
REQ-029 Assert R_N=0 asynchronously between edges with S=2 and P=1 -> Q=0 and Q_VALID=0 immediately; after release, the first Q_VALID occurs 2 CE edges later and S=0.
REQ-030 IS_D_INVERTED=1, D=0 -> steady Q=4'b1111; IS_C_INVERTED=1 with the REQ-027 stimulus -> steady Q=4'b0101.
REQ-031 WIDTH=4, RATIO=8, distinct per-lane patterns -> each lane's word lands only in its own Q slice, with no cross-lane bits.

Source files
------------

// File: rtl/iddr_deser.sv
// Multi-lane DDR input deserialiser with word framing and bitslip alignment.
module iddr_deser #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      RATIO         = 4,
    parameter logic             IS_C_INVERTED = 1'b0,
    parameter logic [WIDTH-1:0] IS_D_INVERTED = {WIDTH{1'b0}}
) (
    input  logic                     C,
    input  logic                     R_N,
    input  logic                     CE,
    input  logic [WIDTH-1:0]         D,
    input  logic                     BITSLIP,
    output logic [WIDTH*RATIO-1:0]   Q,
    output logic                     Q_VALID
);

    localparam int unsigned HW   = 2 * RATIO;
    localparam int unsigned HALF = RATIO / 2;
    localparam int unsigned PW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned SW   = $clog2(RATIO);

    logic                          c_in;
    logic [WIDTH-1:0]              d_pol;

    logic [WIDTH-1:0]              r_q, r_d;
    logic [WIDTH-1:0]              f_q, f_d;
    logic [WIDTH-1:0]              rp_q, rp_d;
    logic [WIDTH-1:0]              fp_q, fp_d;
    logic [WIDTH-1:0][HW-1:0]      h_q, h_d;
    logic [WIDTH-1:0][HW-1:0]      h_next;
    logic [PW-1:0]                 p_q, p_d;
    logic [SW-1:0]                 s_q, s_d;
    logic [WIDTH*RATIO-1:0]        q_q, q_d;
    logic                          q_valid_q, q_valid_d;
    logic                          p_last;

    // Optional clock inversion ahead of every capture flop.
    assign c_in  = C ^ IS_C_INVERTED;
    assign d_pol = D ^ IS_D_INVERTED;

    // Next-state for capture, pairing, history, phase, slip and word output.
    always_comb begin
        r_d       = d_pol;
        f_d       = d_pol;
        rp_d      = r_q;
        fp_d      = f_q;
        h_d       = h_q;
        p_d       = p_q;
        s_d       = s_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        p_last    = (p_q == PW'(HALF - 1));

        for (int unsigned i = 0; i < WIDTH; i++) begin
            h_next[i] = HW'({h_q[i], rp_q[i], fp_q[i]});
        end

        if (CE) begin
            h_d = h_next;
            p_d = p_last ? PW'(0) : p_q + PW'(1);
            if (BITSLIP) begin
                s_d = (s_q == SW'(RATIO - 1)) ? SW'(0) : s_q + SW'(1);
            end
            // Word load uses the slip offset in force before this edge.
            if (p_last) begin
                q_valid_d = 1'b1;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    q_d[i*RATIO +: RATIO] = RATIO'(h_next[i] >> s_q);
                end
            end
        end
    end

    // Rising-edge state: rise capture, aligned pair, history, counters, output word.
    always_ff @(posedge c_in or negedge R_N) begin
        if (!R_N) begin
            r_q       <= '0;
            rp_q      <= '0;
            fp_q      <= '0;
            h_q       <= '0;
            p_q       <= '0;
            s_q       <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            r_q       <= r_d;
            rp_q      <= rp_d;
            fp_q      <= fp_d;
            h_q       <= h_d;
            p_q       <= p_d;
            s_q       <= s_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Falling-edge capture of the second half-cycle bit.
    always_ff @(negedge c_in or negedge R_N) begin
        if (!R_N) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;

endmodule
